// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the accumulator CPU: opcode values,
//               illegal-opcode list, fetch-stage state encoding, default
//               widths and instruction field positions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Default widths
  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 8;

  // Instruction fields: [7:4] opcode, [3:0] operand
  localparam int OPC_LSB = 4;
  localparam int OPC_W   = 4;
  localparam int OPR_LSB = 0;
  localparam int OPR_W   = 4;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_NOP      = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD      = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB      = 4'b0010;
  localparam logic [OPC_W-1:0] OP_AND      = 4'b0011;
  localparam logic [OPC_W-1:0] OP_OR       = 4'b0100;
  localparam logic [OPC_W-1:0] OP_XOR      = 4'b0101;
  localparam logic [OPC_W-1:0] OP_LDI      = 4'b0110;
  localparam logic [OPC_W-1:0] OP_LD       = 4'b0111;
  localparam logic [OPC_W-1:0] OP_JMP      = 4'b1000;
  localparam logic [OPC_W-1:0] OP_JMPZ_IMM = 4'b1010;
  localparam logic [OPC_W-1:0] OP_JMPZ     = 4'b1011;
  localparam logic [OPC_W-1:0] OP_ST       = 4'b1100;
  localparam logic [OPC_W-1:0] OP_OUT      = 4'b1101;
  localparam logic [OPC_W-1:0] OP_HALT     = 4'b1111;

  // Encodings the controller does not recognise
  localparam int N_ILLEGAL = 2;
  localparam logic [OPC_W-1:0] ILLEGAL_OPS [N_ILLEGAL] = '{4'b1001, 4'b1110};

  // Fetch-stage state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

  function automatic logic is_illegal_op(input logic [OPC_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ILLEGAL; i++) begin
      if (op == ILLEGAL_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter register with next-PC selection
//               (hold / +1 / register value / zero-extended immediate).
//               LoadPC has priority over IncPC.
// Ports       : i_clk       - clock, rising edge
//               i_rst_n     - asynchronous active-low reset (PC <= RESET_PC)
//               i_en        - update enable (EXEC cycle with LoadIR set)
//               i_load_pc   - load a jump target
//               i_inc_pc    - increment PC (modulo 2^PC_W)
//               i_sel_pc    - 1: immediate target, 0: register target
//               i_operand   - immediate operand
//               i_reg_val   - register-file value used as target
//               o_pc        - current program counter
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load_pc,
  input  logic             i_inc_pc,
  input  logic             i_sel_pc,
  input  logic [OPR_W-1:0] i_operand,
  input  logic [PC_W-1:0]  i_reg_val,
  output logic [PC_W-1:0]  o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_imm;

  assign w_imm = PC_W'(i_operand);

  always_comb begin
    w_pc_next = r_pc;
    if (i_en) begin
      if (i_load_pc) begin
        w_pc_next = i_sel_pc ? w_imm : i_reg_val;
      end else if (i_inc_pc) begin
        // natural wrap from all-ones back to zero
        w_pc_next = r_pc + PC_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule : pc_unit
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns PC and IR, fetches from IMem
//               over a req/ack handshake, presents Opcode/Operand to the
//               controller and applies its registered strobes in EXEC.
// Ports       : Clk         - clock, rising edge
//               reset_n     - asynchronous active-low reset
//               imem_req    - fetch request (FETCH state only)
//               imem_addr   - fetch address (= PC)
//               imem_ack    - IMem data valid
//               imem_rdata  - fetched instruction
//               Opcode      - IR opcode field, NOP while IR not valid
//               Operand     - IR operand field
//               ir_valid    - IR holds an instruction not yet executed
//               LoadIR, IncPC, SelPC, LoadPC - controller strobes
//               RegVal      - register value used as jump target
//               PC          - program counter
//               halted      - core stopped
//               illegal_op  - stop caused by an unrecognised opcode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               Clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         Opcode,
  output logic [3:0]         Operand,
  output logic               ir_valid,
  input  logic               LoadIR,
  input  logic               IncPC,
  input  logic               SelPC,
  input  logic               LoadPC,
  input  logic [PC_W-1:0]    RegVal,
  output logic [PC_W-1:0]    PC,
  output logic               halted,
  output logic               illegal_op
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [INSTR_W-1:0] r_ir;
  logic               r_ir_valid;
  logic               r_illegal;

  logic               w_ir_load;
  logic               w_ir_clr;
  logic               w_illegal_set;
  logic               w_pc_en;
  logic               w_req;
  logic               w_halted;
  logic [OPC_W-1:0]   w_ir_opc;
  logic [OPR_W-1:0]   w_ir_opr;
  logic [PC_W-1:0]    w_pc;

  assign w_ir_opc = r_ir[OPC_LSB +: OPC_W];
  assign w_ir_opr = r_ir[OPR_LSB +: OPR_W];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_ir_load     = 1'b0;
    w_ir_clr      = 1'b0;
    w_illegal_set = 1'b0;
    w_pc_en       = 1'b0;
    w_req         = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_ir_load    = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // IR is always valid here, so the raw opcode field is used
        if (is_illegal_op(w_ir_opc)) begin
          w_illegal_set = 1'b1;
          w_ir_clr      = 1'b1;
          w_state_next  = ST_HALTED;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_ir_clr = 1'b1;
        if (!LoadIR) begin
          // controller withholds the next fetch: HALT
          w_state_next = ST_HALTED;
        end else begin
          w_pc_en      = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction register and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_ir_load) begin
        r_ir       <= imem_rdata;
        r_ir_valid <= 1'b1;
      end else if (w_ir_clr) begin
        r_ir_valid <= 1'b0;
      end
      if (w_illegal_set) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  pc_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .i_clk     (Clk),
    .i_rst_n   (reset_n),
    .i_en      (w_pc_en),
    .i_load_pc (LoadPC),
    .i_inc_pc  (IncPC),
    .i_sel_pc  (SelPC),
    .i_operand (w_ir_opr),
    .i_reg_val (RegVal),
    .o_pc      (w_pc)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Req decodes from the async-reset state register, so it falls as soon
  // as reset_n is asserted.
  assign imem_req   = w_req;
  assign imem_addr  = w_pc;
  assign PC         = w_pc;
  // Stale controller strobes are harmless: the controller sees NOP here.
  assign Opcode     = r_ir_valid ? w_ir_opc : OP_NOP;
  assign Operand    = w_ir_opr;
  assign ir_valid   = r_ir_valid;
  assign halted     = w_halted;
  assign illegal_op = r_illegal;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit. Stimulus pushes expected
//               fetches (address, spacing, instruction) into a queue; a
//               monitor pops one per fetch request and compares. Also
//               contains an IMem model with wait states and a small
//               controller model driving the strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic       Clk;
  logic       reset_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [3:0] Opcode;
  logic [3:0] Operand;
  logic       ir_valid;
  logic       LoadIR, IncPC, SelPC, LoadPC;
  logic [7:0] RegVal;
  logic [7:0] PC;
  logic       halted;
  logic       illegal_op;

  fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Opcode     (Opcode),
    .Operand    (Operand),
    .ir_valid   (ir_valid),
    .LoadIR     (LoadIR),
    .IncPC      (IncPC),
    .SelPC      (SelPC),
    .LoadPC     (LoadPC),
    .RegVal     (RegVal),
    .PC         (PC),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] addr;
    int         gap;    // cycles since previous request; 0 = not checked
    logic [7:0] instr;
    bit         chk;    // check IR contents after the ack
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur;

  int n_checks;
  int n_fail;
  int n_fetch;
  int cycle;
  bit stall_all;

  logic [7:0] mem  [256];
  logic [7:0] regs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input int g, input logic [7:0] ins, input bit c);
    exp_t e;
    e.addr = a; e.gap = g; e.instr = ins; e.chk = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_fetch(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_fetch < target && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(n_fetch >= target), 32'd1);
  endtask

  task automatic wait_halted(input int budget, input string name);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  task automatic check_reset_state();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", 32'(PC), 32'h00);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_opcode", 32'(Opcode), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
  endtask

  // Cycle counter
  initial begin
    cycle = 0;
    forever begin
      @(posedge Clk);
      cycle++;
    end
  end

  // IMem model: address 0x3D has two wait states, stall_all stalls forever
  function automatic int waits_for(input logic [7:0] a);
    if (stall_all) return 1000;
    if (a == 8'h3D) return 2;
    return 0;
  endfunction

  initial begin
    int wcnt;
    wcnt       = 0;
    imem_ack   = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge Clk);
      if (imem_req) begin
        if (wcnt >= waits_for(imem_addr)) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // Controller model: strobes derived from the presented Opcode
  initial begin
    LoadIR = 1'b1; IncPC = 1'b0; SelPC = 1'b0; LoadPC = 1'b0; RegVal = 8'h00;
    forever begin
      @(negedge Clk);
      LoadIR = (Opcode != 4'hF);
      IncPC  = 1'b1;
      LoadPC = 1'b0;
      SelPC  = 1'b0;
      RegVal = regs[Operand];
      case (Opcode)
        4'h8: begin LoadPC = 1'b1; IncPC = 1'b0; end               // JMP reg
        4'hA: begin LoadPC = 1'b1; IncPC = 1'b0; SelPC = 1'b1; end // JMPZ_IMM taken
        4'hB: begin LoadPC = 1'b1; IncPC = 1'b1; end               // both strobes high
        default: ;
      endcase
    end
  end

  // Monitor
  initial begin
    logic prev_req;
    int   last_rise;
    prev_req  = 1'b0;
    last_rise = 0;
    have_cur  = 1'b0;
    forever begin
      @(negedge Clk);
      if (imem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fetch: got request at 0x%0h, expected none", imem_addr);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          n_fetch++;
          check("fetch_addr", 32'(imem_addr), 32'(cur.addr));
          check("fetch_pc", 32'(PC), 32'(cur.addr));
          if (cur.gap != 0) check("fetch_gap", 32'(cycle - last_rise), 32'(cur.gap));
        end
        last_rise = cycle;
      end
      if (imem_req && have_cur) begin
        check("addr_stable", 32'(imem_addr), 32'(cur.addr));
        check("ir_invalid_in_fetch", 32'(ir_valid), 32'd0);
      end
      if (!imem_req && prev_req && reset_n && have_cur && cur.chk) begin
        check("ir_contents", 32'({Opcode, Operand}), 32'(cur.instr));
        check("ir_valid_after_ack", 32'(ir_valid), 32'd1);
      end
      prev_req = imem_req;
    end
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int base;
    n_checks  = 0;
    n_fail    = 0;
    n_fetch   = 0;
    stall_all = 1'b0;
    reset_n   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    mem[8'h02] = 8'hA5;   // JMPZ_IMM 5
    mem[8'h05] = 8'h83;   // JMP r3
    mem[8'h3E] = 8'h84;   // JMP r4
    mem[8'h10] = 8'hF0;   // HALT
    regs[3] = 8'h3C;
    regs[4] = 8'hFF;
    regs[6] = 8'h10;

    // ---------------- Run 1: program flow, waits, jumps, wrap, HALT -------
    repeat (3) step();
    check_reset_state();
    push(8'h00, 0, 8'h00, 1);
    push(8'h01, 3, 8'h00, 1);
    push(8'h02, 3, 8'hA5, 1);
    push(8'h05, 3, 8'h83, 1);
    push(8'h3C, 3, 8'h00, 1);
    push(8'h3D, 3, 8'h00, 1);
    push(8'h3E, 5, 8'h84, 1);
    push(8'hFF, 3, 8'h00, 1);
    push(8'h00, 3, 8'hB6, 1);
    push(8'h10, 3, 8'hF0, 1);
    reset_n = 1'b1;
    #1 check("req_idle_after_release", 32'(imem_req), 32'd0);
    step();
    check("req_one_cycle_after_release", 32'(imem_req), 32'd1);
    wait_fetch(2, 50, "wait_second_fetch");
    mem[8'h00] = 8'hB6;   // second visit: LoadPC+IncPC with r6
    wait_halted(200, "wait_halt");
    check("run1_fetch_count", 32'(n_fetch), 32'd10);
    repeat (20) begin
      step();
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_pc", 32'(PC), 32'h10);
      check("halt_ir_valid", 32'(ir_valid), 32'd0);
      check("halt_illegal", 32'(illegal_op), 32'd0);
    end
    check("run1_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- Run 2: illegal opcode -------------------------------
    reset_n    = 1'b0;
    mem[8'h00] = 8'h90;
    step();
    check_reset_state();
    push(8'h00, 0, 8'h90, 1);
    reset_n = 1'b1;
    wait_halted(50, "wait_illegal_halt");
    step();
    check("illegal_flag", 32'(illegal_op), 32'd1);
    check("illegal_halted", 32'(halted), 32'd1);
    check("illegal_pc", 32'(PC), 32'h00);
    check("illegal_req", 32'(imem_req), 32'd0);

    // ---------------- Run 3: reset during a stalled fetch -----------------
    reset_n    = 1'b0;
    mem[8'h00] = 8'h00;
    stall_all  = 1'b1;
    step();
    push(8'h00, 0, 8'h00, 0);
    reset_n = 1'b1;
    step();
    check("stall_req_up", 32'(imem_req), 32'd1);
    step();
    step();
    check("stall_req_held", 32'(imem_req), 32'd1);
    check("stall_addr_held", 32'(imem_addr), 32'h00);
    reset_n = 1'b0;
    #1;
    check("req_drop_async", 32'(imem_req), 32'd0);
    check("mid_rst_pc", 32'(PC), 32'h00);
    check("mid_rst_ir_valid", 32'(ir_valid), 32'd0);
    step();
    step();
    stall_all = 1'b0;
    base = n_fetch;
    push(8'h00, 0, 8'h00, 1);
    push(8'h01, 3, 8'h00, 1);
    reset_n = 1'b1;
    #1 check("restart_req_idle", 32'(imem_req), 32'd0);
    step();
    check("restart_req_up", 32'(imem_req), 32'd1);
    wait_fetch(base + 2, 50, "wait_restart_fetches");
    step();
    step();
    reset_n = 1'b0;
    step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the accumulator CPU: owns the program counter (PC) and instruction register (IR), and fetches from instruction memory over a req/ack handshake.
- Presents Opcode/Operand to the controller and consumes the controller's registered strobes: LoadIR, IncPC, SelPC, LoadPC.
- Sits between IMem and the controller; the datapath reads Operand and drives RegVal.

Parameters:
- PC_W, 8, PC and IMem address width.
- INSTR_W, 8, instruction width; [7:4] opcode, [3:0] operand (register index or immediate).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request to IMem.
- imem_addr  out  PC_W  fetch address; equals PC.
- imem_ack  in  1  IMem data valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- Opcode  out  4  to controller; IR[7:4] when ir_valid, else NOP (0000).
- Operand  out  4  IR[3:0]; register index or immediate.
- ir_valid  out  1  IR holds an instruction not yet executed.
- LoadIR, IncPC, SelPC, LoadPC  in  1 each  controller strobes.
- RegVal  in  PC_W  register-file read value used as jump target.
- PC  out  PC_W  current program counter.
- halted  out  1  core stopped (HALT or illegal opcode).
- illegal_op  out  1  stop was caused by an unrecognized opcode.

Behaviour:
- Clock and reset are decided: one clock, Clk; reset is asynchronous and active-low, reset_n.
- Reset values:
  - State is IDLE; PC = RESET_PC.
  - IR = 0, so ir_valid = 0 and Opcode = 0000.
  - imem_req = 0, halted = 0, illegal_op = 0.
- imem_req is 1 only in FETCH; asserting reset_n low mid-fetch drops it immediately.
- States and transitions:
  - IDLE: always goes to FETCH on the next edge.
  - FETCH: imem_req = 1 and imem_addr = PC, both held stable until imem_ack. Ack in the same cycle as req is legal. On the ack edge, IR <= imem_rdata, ir_valid <= 1, go to DECODE.
  - DECODE: one cycle, covering the controller's registered latency. The controller samples Opcode at the end of this cycle. If the opcode is 1001 or 1110 (unrecognized), go to HALTED with illegal_op <= 1; PC is not changed.
  - EXEC: strobes are valid this cycle and are sampled at its closing edge. Rules, in priority order:
    - LoadIR = 0: go to HALTED; PC is unchanged.
    - LoadPC = 1: PC <= (SelPC ? zero-extended Operand : RegVal).
    - else IncPC = 1: PC <= PC + 1, modulo 2^PC_W (0xFF wraps to 0x00).
    - else: PC is unchanged.
    - LoadPC and IncPC both 1: LoadPC wins.
    - In every non-halting case: ir_valid <= 0, go to FETCH.
  - HALTED: halted = 1, imem_req = 0, ir_valid = 0. IR and PC are frozen. Only reset exits.
- Strobes are ignored outside EXEC. While ir_valid = 0, Opcode reads NOP, so stale controller strobes have no effect.
- Per-instruction latency: FETCH (at least 1 cycle, plus IMem wait) + DECODE (1) + EXEC (1). With zero-wait IMem this is 3 cycles.
- PC update, IR load and ir_valid are all registered; there is no combinational path from the strobes to PC.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (ADD..HALT, NOP);
  - the illegal-opcode list;
  - the fetch state encoding (IDLE, FETCH, DECODE, EXEC, HALTED);
  - PC_W and INSTR_W defaults;
  - instruction field positions.
- One sub-module, pc_unit: the PC register plus the next-PC mux (hold / +1 / RegVal / immediate) with LoadPC-over-IncPC priority.

Test Plan:
- Reset, then NOP at 0x00 with zero-wait ack: imem_req rises 1 cycle after reset release. PC reads 0x00 → 0x01 → 0x02, one step every 3 cycles.
- IMem with 2-wait-state ack: imem_req and imem_addr stay stable for 3 cycles; IR is loaded only on the ack edge.
- JMPZ_IMM with operand 0x5 and strobes LoadPC = 1, SelPC = 1: next imem_addr = 0x05. Same with SelPC = 0 and RegVal = 0x3C: next imem_addr = 0x3C.
- PC = 0xFF with IncPC: PC wraps to 0x00. LoadPC and IncPC both high with RegVal = 0x10: PC = 0x10.
- HALT (0xF0): EXEC sees LoadIR = 0 → halted = 1, imem_req stays 0, PC frozen for 20 cycles. Opcode 0x9 → halted = 1 and illegal_op = 1 after DECODE.
- reset_n asserted low mid-FETCH: imem_req drops the same cycle. After release: PC = RESET_PC, ir_valid = 0, fetch restarts from IDLE.
